// File: rtl/lut_pkg.sv
// Shared types and helpers for the runtime-writable key/data lookup table.
package lut_pkg;

   localparam int unsigned KEY_LEN_DFLT  = 2;
   localparam int unsigned DATA_LEN_DFLT = 4;
   localparam int unsigned PAIR_LEN      = KEY_LEN_DFLT + DATA_LEN_DFLT;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

   function automatic int unsigned idx_w(input int unsigned item_num);
      return (item_num <= 2) ? 1 : $clog2(item_num);
   endfunction

endpackage

// File: rtl/lut_match.sv
// Combinational key match against all valid entries; lowest matching index wins.
module lut_match
   import lut_pkg::*;
#(
   parameter int unsigned KEY_LEN     = KEY_LEN_DFLT,
   parameter int unsigned DATA_LEN    = DATA_LEN_DFLT,
   parameter int unsigned ITEM_NUM    = 4,
   parameter bit          HAS_DEFAULT = 1'b1,
   localparam int unsigned IDX_W      = idx_w(ITEM_NUM)
) (
   input  logic [KEY_LEN-1:0]           key_i,
   input  logic [ITEM_NUM*KEY_LEN-1:0]  keys_i,
   input  logic [ITEM_NUM*DATA_LEN-1:0] data_i,
   input  logic [ITEM_NUM-1:0]          valid_i,
   input  logic [DATA_LEN-1:0]          default_i,
   output logic                         hit_o,
   output logic [DATA_LEN-1:0]          data_o,
   output logic [IDX_W-1:0]             idx_o
);

   always_comb begin
      hit_o  = 1'b0;
      idx_o  = '0;
      data_o = HAS_DEFAULT ? default_i : '0;
      // Scan high to low so the lowest matching index overwrites last.
      for (int i = ITEM_NUM - 1; i >= 0; i--) begin
         if (valid_i[i] && (keys_i[i*KEY_LEN +: KEY_LEN] == key_i)) begin
            hit_o  = 1'b1;
            idx_o  = IDX_W'(i);
            data_o = data_i[i*DATA_LEN +: DATA_LEN];
         end
      end
   end

endmodule

// File: rtl/lut_ctrl.sv
// Writable lookup table shared by two requesters via round-robin arbitration,
// with a single registered response slot behind a valid/ready handshake.
module lut_ctrl
   import lut_pkg::*;
#(
   parameter int unsigned KEY_LEN     = KEY_LEN_DFLT,
   parameter int unsigned DATA_LEN    = DATA_LEN_DFLT,
   parameter int unsigned ITEM_NUM    = 4,
   parameter bit          HAS_DEFAULT = 1'b1,
   localparam int unsigned IDX_W      = idx_w(ITEM_NUM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  inv_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [KEY_LEN-1:0]    wr_key,
   input  logic [DATA_LEN-1:0]   wr_data,
   input  logic [DATA_LEN-1:0]   default_out,
   input  logic [1:0]            req_valid,
   input  logic [2*KEY_LEN-1:0]  req_key,
   output logic [1:0]            req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic                  rsp_hit,
   output logic [DATA_LEN-1:0]   rsp_data
);

   logic [ITEM_NUM*KEY_LEN-1:0]  keys_q, keys_d;
   logic [ITEM_NUM*DATA_LEN-1:0] datas_q, datas_d;
   logic [ITEM_NUM-1:0]          valid_q, valid_d;
   slot_e                        slot_q, slot_d;
   logic                         ptr_q, ptr_d;
   logic                         rsp_id_q, rsp_id_d;
   logic                         rsp_hit_q, rsp_hit_d;
   logic [DATA_LEN-1:0]          rsp_data_q, rsp_data_d;

   logic [1:0]          grant;
   logic                accept;
   logic                slot_free;
   logic [KEY_LEN-1:0]  sel_key;
   logic                match_hit;
   logic [DATA_LEN-1:0] match_data;
   logic [IDX_W-1:0]    unused_match_idx;

   // Table programming; invalidate takes precedence over write.
   always_comb begin
      keys_d  = keys_q;
      datas_d = datas_q;
      valid_d = valid_q;
      if (int'(wr_idx) < int'(ITEM_NUM)) begin
         if (inv_en) begin
            valid_d[wr_idx] = 1'b0;
         end else if (wr_en) begin
            valid_d[wr_idx]                        = 1'b1;
            keys_d[wr_idx*KEY_LEN +: KEY_LEN]      = wr_key;
            datas_d[wr_idx*DATA_LEN +: DATA_LEN]   = wr_data;
         end
      end
   end

   // Round-robin arbiter, only granting when the response slot can take a result.
   always_comb begin
      slot_free = ~rst & ((slot_q == SLOT_EMPTY) | rsp_ready);
      grant     = 2'b00;
      if (slot_free) begin
         if (req_valid[ptr_q]) begin
            grant[ptr_q] = 1'b1;
         end else if (req_valid[~ptr_q]) begin
            grant[~ptr_q] = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (grant[0]) begin
         ptr_d = 1'b1;
      end else if (grant[1]) begin
         ptr_d = 1'b0;
      end
      accept  = |grant;
      sel_key = grant[1] ? req_key[2*KEY_LEN-1:KEY_LEN] : req_key[KEY_LEN-1:0];
   end

   lut_match #(
      .KEY_LEN     (KEY_LEN),
      .DATA_LEN    (DATA_LEN),
      .ITEM_NUM    (ITEM_NUM),
      .HAS_DEFAULT (HAS_DEFAULT)
   ) u_match (
      .key_i     (sel_key),
      .keys_i    (keys_q),
      .data_i    (datas_q),
      .valid_i   (valid_q),
      .default_i (default_out),
      .hit_o     (match_hit),
      .data_o    (match_data),
      .idx_o     (unused_match_idx)
   );

   // Slot next state.
   always_comb begin
      slot_d = slot_q;
      unique case (slot_q)
         SLOT_EMPTY: if (accept) slot_d = SLOT_FULL;
         SLOT_FULL:  if (!accept && rsp_ready) slot_d = SLOT_EMPTY;
         default:    slot_d = SLOT_EMPTY;
      endcase
      rsp_id_d   = accept ? grant[1]   : rsp_id_q;
      rsp_hit_d  = accept ? match_hit  : rsp_hit_q;
      rsp_data_d = accept ? match_data : rsp_data_q;
   end

   // Outputs.
   always_comb begin
      rsp_valid = (slot_q == SLOT_FULL);
      req_ready = grant;
      rsp_id    = rsp_id_q;
      rsp_hit   = rsp_hit_q;
      rsp_data  = rsp_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         keys_q     <= '0;
         datas_q    <= '0;
         valid_q    <= '0;
         slot_q     <= SLOT_EMPTY;
         ptr_q      <= 1'b0;
         rsp_id_q   <= 1'b0;
         rsp_hit_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         keys_q     <= keys_d;
         datas_q    <= datas_d;
         valid_q    <= valid_d;
         slot_q     <= slot_d;
         ptr_q      <= ptr_d;
         rsp_id_q   <= rsp_id_d;
         rsp_hit_q  <= rsp_hit_d;
         rsp_data_q <= rsp_data_d;
      end
   end

endmodule

// File: doc/lut_ctrl.md
Name: lut_ctrl

Overview:
Register-backed key/data lookup table with a runtime programming port. A single lookup engine is shared between two requesters through a round-robin arbiter. Accepts at most one lookup per cycle and returns a registered response (data, hit, requester id) behind a valid/ready handshake. It is the sequenced, writable counterpart of the team's combinational key/value mux table, for use where table contents change at runtime.

Parameters:
KEY_LEN, 2, key width in bits
DATA_LEN, 4, data width in bits
ITEM_NUM, 4, number of table entries (>=2)
HAS_DEFAULT, 1, 1: a miss returns default_out; 0: a miss returns all-zeros

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
wr_en  input  1  program entry wr_idx with {wr_key, wr_data} and mark it valid
inv_en  input  1  invalidate entry wr_idx
wr_idx  input  IDX_W  entry index; IDX_W = max(1, clog2(ITEM_NUM))
wr_key  input  KEY_LEN  key to store
wr_data  input  DATA_LEN  data to store
default_out  input  DATA_LEN  miss value, sampled in the accept cycle
req_valid  input  2  per-requester lookup request
req_key  input  2*KEY_LEN  requester n key at [KEY_LEN*(n+1)-1 : KEY_LEN*n]
req_ready  output  2  one-hot grant; combinational
rsp_valid  output  1  response held in output register
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester that issued the response
rsp_hit  output  1  key matched a valid entry
rsp_data  output  DATA_LEN  looked-up data or miss value

Behaviour:
- Reset: all entries invalid with key/data 0; rsp_valid=0; rsp_id=0; rsp_hit=0; rsp_data=0; priority pointer points to requester 0. req_ready=0 while rst=1. Reset mid-operation discards any stalled response and the table contents.
- Output slot states:
  - EMPTY (rsp_valid=0) -> FULL on accept.
  - FULL -> EMPTY when rsp_ready=1 and no new accept that cycle.
  - FULL -> FULL on a stall, or on consume plus accept in the same cycle.
- Slot is free when rsp_valid=0 or rsp_ready=1. This gives full throughput: one response per cycle.
- Arbitration: if the slot is free, grant one requester with req_valid=1. The priority pointer requester wins if requesting, otherwise the other. On a grant to n, the pointer moves to 1-n. With no grant, the pointer is unchanged. req_ready is one-hot or zero and never asserted when the slot is not free.
- Lookup: the granted key is compared against every entry with valid=1. Invalid entries never match, even when their stored key equals the request. On multiple matches, the lowest index wins.
- Latency: exactly 1 cycle from the accept edge to rsp_valid=1.
- Miss value: default_out when HAS_DEFAULT=1, all-zeros when HAS_DEFAULT=0. rsp_hit=0 in both cases.
- Stall: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs are held stable. default_out changes do not affect a held response.
- Writes:
  - Table updates take effect at the next edge. A lookup accepted in the same cycle as a write sees the old contents.
  - inv_en and wr_en together on the same index: inv_en wins.
  - wr_idx >= ITEM_NUM: the write or invalidate is ignored.
  - Writes proceed regardless of lookup or stall state.

Decomposition:
- Package lut_pkg holds:
  - function idx_w(ITEM_NUM)
  - localparam PAIR_LEN = KEY_LEN + DATA_LEN
  - slot state encoding SLOT_EMPTY / SLOT_FULL
- Sub-module lut_match: purely combinational. Inputs are a key, the flattened entry keys, data and valid bits, and the default. Outputs are hit, data, and the matching index, using a lowest-index priority encoder. Instantiated once in lut_ctrl, fed by the granted-key mux.

Test Plan:
1. Reset; program 0:{00,F}, 1:{01,D}, 2:{10,B}; req0 key 01, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_hit=1, rsp_data=D.
2. HAS_DEFAULT=1, default_out=A, req1 key 11 -> rsp_hit=0, rsp_data=A. With HAS_DEFAULT=0 -> rsp_data=0.
3. Both req_valid held high, rsp_ready=1 -> req_ready sequence 01, 10, 01, 10; one response per cycle with rsp_id alternating 0,1,0,1.
4. rsp_ready=0 for 3 cycles with a response pending -> rsp_* stable, req_ready=00, pointer unchanged. On release, the consume and the next accept occur in the same cycle.
5. wr_en idx1 {01,7} in the same cycle as accepting key 01 -> response data D; the next lookup of 01 returns 7. Program idx0 and idx3 both with key 11 -> lookup returns idx0 data. inv_en idx0 -> returns idx3 data.
6. Assert rst for 1 cycle while a response is stalled -> rsp_valid=0 the next cycle. A lookup of key 00 then misses, because zeroed entries are invalid.
